// File: rtl/intr_dispatch_if.sv
// intr_dispatch_if: bus bundle for intr_dispatch.
// Carries the APB-style register bus (paddr_i, pwdata_i, pwrite_i, psel_i,
// penable_i in; prdata_o, pready_o out) and the capture handshake with
// intr_ctrl (intr_id_i, intr_valid_i in; intr_ack_o out). Signal suffixes
// are from the dispatcher's point of view.
//   master : bus driver / interrupt controller side
//   slave  : intr_dispatch side
interface intr_dispatch_if #(
  parameter int WIDTH  = 4,
  parameter int DATA_W = 8
);
  logic [WIDTH-1:0]  paddr_i;
  logic [DATA_W-1:0] pwdata_i;
  logic [DATA_W-1:0] prdata_o;
  logic              pwrite_i;
  logic              psel_i;
  logic              penable_i;
  logic              pready_o;
  logic [WIDTH-1:0]  intr_id_i;
  logic              intr_valid_i;
  logic              intr_ack_o;

  modport master (
    output paddr_i, pwdata_i, pwrite_i, psel_i, penable_i,
    output intr_id_i, intr_valid_i,
    input  prdata_o, pready_o, intr_ack_o
  );

  modport slave (
    input  paddr_i, pwdata_i, pwrite_i, psel_i, penable_i,
    input  intr_id_i, intr_valid_i,
    output prdata_o, pready_o, intr_ack_o
  );
endinterface

// File: rtl/intr_dispatch.sv
// intr_dispatch: accepts interrupts from intr_ctrl into a small FIFO and
// hands them round-robin to idle, enabled handler CPUs, supervising each
// service with a programmable timeout.
// Ports:
//   pclk_i, prst_i   clock, synchronous active-high reset
//   bus              intr_dispatch_if.slave (APB registers + capture handshake)
//   cpu_intr_req_o   per-CPU service request (level, high while BUSY)
//   cpu_intr_id_o    per-CPU interrupt ID, CPU c at [c*WIDTH +: WIDTH]
//   cpu_done_i       per-CPU service-complete strobe
//   tmo_irq_o        high while any timeout sticky bit is set (registered)
// Registers: 0 EN (RW), 1 TMO (RW), 2 TSTAT (W1C), 3 STATUS (RO: busy, count)
module intr_dispatch #(
  parameter int NUM_INTR = 16,
  parameter int WIDTH    = $clog2(NUM_INTR),
  parameter int NUM_CPU  = 2,
  parameter int DEPTH    = 4,
  parameter int DATA_W   = 8
) (
  input  logic                     pclk_i,
  input  logic                     prst_i,
  intr_dispatch_if.slave           bus,
  output logic [NUM_CPU-1:0]       cpu_intr_req_o,
  output logic [NUM_CPU*WIDTH-1:0] cpu_intr_id_o,
  input  logic [NUM_CPU-1:0]       cpu_done_i,
  output logic                     tmo_irq_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int CPU_W = $clog2(NUM_CPU);

  localparam logic [WIDTH-1:0] ADDR_EN     = WIDTH'(0);
  localparam logic [WIDTH-1:0] ADDR_TMO    = WIDTH'(1);
  localparam logic [WIDTH-1:0] ADDR_TSTAT  = WIDTH'(2);
  localparam logic [WIDTH-1:0] ADDR_STATUS = WIDTH'(3);

  typedef enum logic {CPU_IDLE = 1'b0, CPU_BUSY = 1'b1} cpu_state_t;

  // Register file and APB
  logic                pready_reg;
  logic [DATA_W-1:0]   prdata_reg;
  logic [NUM_CPU-1:0]  en_reg;
  logic [7:0]          tmo_reg;
  logic [NUM_CPU-1:0]  tstat_reg;
  logic                tmo_irq_reg;
  logic [DATA_W-1:0]   rd_data;
  logic                apb_fire;
  logic                apb_wr;
  logic [NUM_CPU-1:0]  tstat_clr;

  // FIFO and dispatch
  logic [WIDTH-1:0]    fifo_mem [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_reg;
  logic [PTR_W-1:0]    rd_ptr_reg;
  logic [CNT_W-1:0]    count_reg;
  logic                ack_reg;
  logic                push;
  logic                dispatch;
  logic [CPU_W-1:0]    rr_ptr_reg;
  logic [CPU_W-1:0]    grant_idx;
  logic                grant_found;
  logic [NUM_CPU-1:0]  busy;
  logic [NUM_CPU-1:0]  cand;
  logic [NUM_CPU-1:0]  tmo_set;

  // One wait state: the access completes on the edge after setup+enable.
  assign apb_fire  = bus.psel_i & bus.penable_i & ~pready_reg;
  assign apb_wr    = apb_fire & bus.pwrite_i;
  assign tstat_clr = (apb_wr && bus.paddr_i == ADDR_TSTAT) ? bus.pwdata_i[NUM_CPU-1:0] : '0;

  always_comb begin
    rd_data = '0;
    case (bus.paddr_i)
      ADDR_EN:     rd_data[NUM_CPU-1:0] = en_reg;
      ADDR_TMO:    rd_data[7:0] = tmo_reg;
      ADDR_TSTAT:  rd_data[NUM_CPU-1:0] = tstat_reg;
      ADDR_STATUS: begin
        rd_data[NUM_CPU-1:0]     = busy;
        rd_data[NUM_CPU +: CNT_W] = count_reg;
      end
      default: ;
    endcase
  end

  always_ff @(posedge pclk_i) begin
    if (prst_i) begin
      pready_reg  <= 1'b0;
      prdata_reg  <= '0;
      en_reg      <= '1;
      tmo_reg     <= '0;
      tstat_reg   <= '0;
      tmo_irq_reg <= 1'b0;
    end else begin
      pready_reg <= apb_fire;
      if (apb_fire && !bus.pwrite_i) prdata_reg <= rd_data;
      if (apb_wr && bus.paddr_i == ADDR_EN)  en_reg  <= bus.pwdata_i[NUM_CPU-1:0];
      if (apb_wr && bus.paddr_i == ADDR_TMO) tmo_reg <= bus.pwdata_i[7:0];
      // A timeout landing on the same edge as its clear must survive.
      tstat_reg   <= (tstat_reg & ~tstat_clr) | tmo_set;
      tmo_irq_reg <= |tstat_reg;
    end
  end

  // Capture: ack_reg gates the push so the controller's still-high valid
  // during the ack cycle is not taken twice. Full blocks even with a pop.
  assign push = bus.intr_valid_i & (count_reg != CNT_W'(DEPTH)) & ~ack_reg;

  always_ff @(posedge pclk_i) begin
    if (push) fifo_mem[wr_ptr_reg] <= bus.intr_id_i;
  end

  always_ff @(posedge pclk_i) begin
    if (prst_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      ack_reg    <= 1'b0;
      rr_ptr_reg <= CPU_W'(NUM_CPU - 1);
    end else begin
      ack_reg <= push;
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (dispatch) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
        rr_ptr_reg <= grant_idx;
      end
      count_reg <= count_reg + CNT_W'(push) - CNT_W'(dispatch);
    end
  end

  // Round-robin search starting one past the last granted CPU.
  assign cand = en_reg & ~busy;

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 1; k <= NUM_CPU; k++) begin
      if (!grant_found && cand[(int'(rr_ptr_reg) + k) % NUM_CPU]) begin
        grant_found = 1'b1;
        grant_idx   = CPU_W'((int'(rr_ptr_reg) + k) % NUM_CPU);
      end
    end
  end

  assign dispatch = (count_reg != '0) & grant_found;

  generate
    for (genvar gi = 0; gi < NUM_CPU; gi++) begin : g_cpu
      cpu_state_t       state_reg;
      logic [7:0]       timer_reg;
      logic [WIDTH-1:0] id_reg;
      logic             granted;

      assign granted = dispatch && (grant_idx == CPU_W'(gi));

      // Timer loaded with 0 never reaches 1, which disables the timeout.
      always_ff @(posedge pclk_i) begin
        if (prst_i) begin
          state_reg <= CPU_IDLE;
          timer_reg <= '0;
          id_reg    <= '0;
        end else begin
          case (state_reg)
            CPU_IDLE: begin
              if (granted) begin
                state_reg <= CPU_BUSY;
                timer_reg <= tmo_reg;
                id_reg    <= fifo_mem[rd_ptr_reg];
              end
            end
            CPU_BUSY: begin
              if (cpu_done_i[gi] || timer_reg == 8'd1) begin
                state_reg <= CPU_IDLE;
              end else if (timer_reg != 8'd0) begin
                timer_reg <= timer_reg - 8'd1;
              end
            end
            default: state_reg <= CPU_IDLE;
          endcase
        end
      end

      assign busy[gi]    = (state_reg == CPU_BUSY);
      assign tmo_set[gi] = busy[gi] & ~cpu_done_i[gi] & (timer_reg == 8'd1);
      assign cpu_intr_id_o[gi*WIDTH +: WIDTH] = id_reg;
    end
  endgenerate

  assign cpu_intr_req_o = busy;
  assign tmo_irq_o      = tmo_irq_reg;
  assign bus.prdata_o   = prdata_reg;
  assign bus.pready_o   = pready_reg;
  assign bus.intr_ack_o = ack_reg;
endmodule

// File: tb/tb_intr_dispatch.sv
// tb_intr_dispatch: directed, table-driven bench for intr_dispatch.
// Register accesses come from a vector table; multi-cycle behaviour
// (capture, round-robin, backpressure, timeout, tie, reset) is hand-sequenced.
module tb_intr_dispatch;
  localparam int WIDTH   = 4;
  localparam int NUM_CPU = 2;
  localparam int DATA_W  = 8;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic [NUM_CPU-1:0]       cpu_done = '0;
  logic [NUM_CPU-1:0]       cpu_req;
  logic [NUM_CPU*WIDTH-1:0] cpu_ids;
  logic                     tmo_irq;

  int checks   = 0;
  int failures = 0;

  intr_dispatch_if #(.WIDTH(WIDTH), .DATA_W(DATA_W)) bus ();

  intr_dispatch #(
    .NUM_INTR(16), .WIDTH(WIDTH), .NUM_CPU(NUM_CPU), .DEPTH(4), .DATA_W(DATA_W)
  ) dut (
    .pclk_i        (clk),
    .prst_i        (rst),
    .bus           (bus),
    .cpu_intr_req_o(cpu_req),
    .cpu_intr_id_o (cpu_ids),
    .cpu_done_i    (cpu_done),
    .tmo_irq_o     (tmo_irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         wr;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp;
  } apb_vec_t;

  apb_vec_t vecs [17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apb_xfer(input bit wr, input logic [3:0] addr, input logic [7:0] wdata,
                          output logic [7:0] rdata);
    int n;
    bus.psel_i    = 1'b1;
    bus.penable_i = 1'b0;
    bus.pwrite_i  = wr;
    bus.paddr_i   = addr;
    bus.pwdata_i  = wdata;
    tick();
    bus.penable_i = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.pready_o && n < 4);
    chk("apb_pready", {31'd0, bus.pready_o}, 32'd1);
    rdata         = bus.prdata_o;
    bus.psel_i    = 1'b0;
    bus.penable_i = 1'b0;
    bus.pwrite_i  = 1'b0;
    $display("apb wr=%0d addr=%0h wdata=%02h rdata=%02h", wr, addr, wdata, rdata);
  endtask

  task automatic apb_rd_chk(input string name, input logic [3:0] addr, input logic [7:0] exp);
    logic [7:0] d;
    apb_xfer(1'b0, addr, 8'h00, d);
    chk(name, {24'd0, d}, {24'd0, exp});
  endtask

  task automatic apb_wr(input logic [3:0] addr, input logic [7:0] data);
    logic [7:0] d;
    apb_xfer(1'b1, addr, data, d);
  endtask

  task automatic push_try(input logic [3:0] id, input int max_cycles, output bit got);
    bus.intr_valid_i = 1'b1;
    bus.intr_id_i    = id;
    got = 1'b0;
    for (int n = 0; n < max_cycles && !got; n++) begin
      tick();
      if (bus.intr_ack_o) got = 1'b1;
    end
    bus.intr_valid_i = 1'b0;
    $display("intr id=%0d acked=%0d", id, got);
  endtask

  task automatic push_chk(input logic [3:0] id);
    bit got;
    push_try(id, 4, got);
    chk($sformatf("push_ack_id%0d", id), {31'd0, got}, 32'd1);
  endtask

  task automatic do_reset();
    rst              = 1'b1;
    cpu_done         = '0;
    bus.intr_valid_i = 1'b0;
    bus.psel_i       = 1'b0;
    bus.penable_i    = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    $display("reset applied");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    int cnt;
    logic [7:0] d;

    vecs[0]  = '{1'b0, 4'h0, 8'h00, 8'h03};
    vecs[1]  = '{1'b0, 4'h1, 8'h00, 8'h00};
    vecs[2]  = '{1'b0, 4'h2, 8'h00, 8'h00};
    vecs[3]  = '{1'b0, 4'h3, 8'h00, 8'h00};
    vecs[4]  = '{1'b0, 4'h4, 8'h00, 8'h00};
    vecs[5]  = '{1'b1, 4'h1, 8'hA5, 8'h00};
    vecs[6]  = '{1'b0, 4'h1, 8'h00, 8'hA5};
    vecs[7]  = '{1'b1, 4'h0, 8'hFD, 8'h00};
    vecs[8]  = '{1'b0, 4'h0, 8'h00, 8'h01};
    vecs[9]  = '{1'b1, 4'h3, 8'hFF, 8'h00};
    vecs[10] = '{1'b0, 4'h3, 8'h00, 8'h00};
    vecs[11] = '{1'b1, 4'h7, 8'h55, 8'h00};
    vecs[12] = '{1'b0, 4'h7, 8'h00, 8'h00};
    vecs[13] = '{1'b1, 4'h0, 8'h03, 8'h00};
    vecs[14] = '{1'b0, 4'h0, 8'h00, 8'h03};
    vecs[15] = '{1'b1, 4'h1, 8'h00, 8'h00};
    vecs[16] = '{1'b0, 4'h1, 8'h00, 8'h00};

    bus.paddr_i      = '0;
    bus.pwdata_i     = '0;
    bus.pwrite_i     = 1'b0;
    bus.psel_i       = 1'b0;
    bus.penable_i    = 1'b0;
    bus.intr_id_i    = '0;
    bus.intr_valid_i = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_req", {30'd0, cpu_req}, 32'd0);
    chk("rst_ids", {24'd0, cpu_ids}, 32'd0);
    chk("rst_ack", {31'd0, bus.intr_ack_o}, 32'd0);
    chk("rst_pready", {31'd0, bus.pready_o}, 32'd0);
    chk("rst_prdata", {24'd0, bus.prdata_o}, 32'd0);
    chk("rst_tmo_irq", {31'd0, tmo_irq}, 32'd0);
    rst = 1'b0;

    // Register table
    for (int i = 0; i < 17; i++) begin
      apb_xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, d);
      if (!vecs[i].wr) chk($sformatf("reg_vec%0d", i), {24'd0, d}, {24'd0, vecs[i].exp});
    end

    // Single interrupt: valid held for two cycles, one ack, req two cycles later
    do_reset();
    bus.intr_valid_i = 1'b1;
    bus.intr_id_i    = 4'd5;
    tick();
    chk("single_ack1", {31'd0, bus.intr_ack_o}, 32'd1);
    chk("single_req_early", {30'd0, cpu_req}, 32'd0);
    tick();
    chk("single_ack2", {31'd0, bus.intr_ack_o}, 32'd0);
    chk("single_req", {30'd0, cpu_req}, 32'd1);
    chk("single_id0", {28'd0, cpu_ids[3:0]}, 32'd5);
    bus.intr_valid_i = 1'b0;
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.intr_ack_o) cnt++;
    end
    chk("single_extra_acks", cnt, 32'd0);
    apb_rd_chk("single_status", 4'h3, 8'h01);
    cpu_done[0] = 1'b1;
    tick();
    cpu_done[0] = 1'b0;
    chk("single_done_req", {30'd0, cpu_req}, 32'd0);
    chk("single_done_id_held", {28'd0, cpu_ids[3:0]}, 32'd5);

    // Round-robin
    do_reset();
    push_chk(4'd1);
    push_chk(4'd2);
    push_chk(4'd3);
    tick();
    chk("rr_req", {30'd0, cpu_req}, 32'd3);
    chk("rr_id0", {28'd0, cpu_ids[3:0]}, 32'd1);
    chk("rr_id1", {28'd0, cpu_ids[7:4]}, 32'd2);
    apb_rd_chk("rr_status_q1", 4'h3, 8'h07);
    cpu_done[0] = 1'b1;
    tick();
    cpu_done[0] = 1'b0;
    chk("rr_release", {30'd0, cpu_req}, 32'd2);
    tick();
    chk("rr_regrant", {30'd0, cpu_req}, 32'd3);
    chk("rr_regrant_id0", {28'd0, cpu_ids[3:0]}, 32'd3);
    apb_rd_chk("rr_status_q0", 4'h3, 8'h03);

    // FIFO full backpressure
    do_reset();
    apb_wr(4'h0, 8'h00);
    push_chk(4'd1);
    push_chk(4'd2);
    push_chk(4'd3);
    push_chk(4'd4);
    push_try(4'd5, 6, got);
    chk("full_5th_withheld", {31'd0, got}, 32'd0);
    apb_rd_chk("full_status", 4'h3, 8'h10);
    apb_wr(4'h0, 8'h03);
    tick();
    tick();
    chk("drain_req", {30'd0, cpu_req}, 32'd3);
    chk("drain_id0", {28'd0, cpu_ids[3:0]}, 32'd1);
    chk("drain_id1", {28'd0, cpu_ids[7:4]}, 32'd2);
    apb_rd_chk("drain_status", 4'h3, 8'h0B);

    // Timeout
    do_reset();
    apb_wr(4'h1, 8'd3);
    push_chk(4'd7);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (cpu_req[0]) cnt++;
    end
    chk("tmo_req_cycles", cnt, 32'd3);
    chk("tmo_irq_set", {31'd0, tmo_irq}, 32'd1);
    apb_rd_chk("tmo_tstat", 4'h2, 8'h01);
    apb_wr(4'h2, 8'h01);
    tick();
    chk("tmo_irq_clr", {31'd0, tmo_irq}, 32'd0);
    apb_rd_chk("tmo_tstat_clr", 4'h2, 8'h00);

    // Done on the expiry cycle wins over the timeout
    do_reset();
    apb_wr(4'h1, 8'd3);
    push_chk(4'd9);
    tick();
    tick();
    tick();
    chk("tie_req_before", {30'd0, cpu_req}, 32'd1);
    cpu_done[0] = 1'b1;
    tick();
    cpu_done[0] = 1'b0;
    chk("tie_req_after", {30'd0, cpu_req}, 32'd0);
    tick();
    tick();
    chk("tie_tmo_irq", {31'd0, tmo_irq}, 32'd0);
    apb_rd_chk("tie_tstat", 4'h2, 8'h00);

    // Mid-operation reset with 2 queued and 2 busy
    do_reset();
    push_chk(4'd1);
    push_chk(4'd2);
    push_chk(4'd3);
    push_chk(4'd4);
    apb_rd_chk("mid_status_before", 4'h3, 8'h0B);
    rst = 1'b1;
    tick();
    chk("mid_rst_req", {30'd0, cpu_req}, 32'd0);
    chk("mid_rst_ids", {24'd0, cpu_ids}, 32'd0);
    chk("mid_rst_ack", {31'd0, bus.intr_ack_o}, 32'd0);
    chk("mid_rst_prdata", {24'd0, bus.prdata_o}, 32'd0);
    chk("mid_rst_tmo_irq", {31'd0, tmo_irq}, 32'd0);
    rst = 1'b0;
    apb_rd_chk("mid_status_after", 4'h3, 8'h00);
    apb_rd_chk("mid_en_after", 4'h0, 8'h03);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/intr_dispatch.md
# intr_dispatch

Interrupt dispatcher between `intr_ctrl` and a group of handler CPUs. It accepts each interrupt selected by the controller and acknowledges it on the controller's `intr_serviced_i`, buffering it in a small FIFO. It hands queued interrupts round-robin to idle, enabled CPUs and supervises each in-flight service with a programmable timeout. Enable mask, timeout and status are accessed over the same APB-style bus as the priority registers.

## Interface
- NUM_INTR, 16, number of interrupt sources
- WIDTH, $clog2(NUM_INTR), interrupt ID width; also APB address width
- NUM_CPU, 2, number of handler CPUs (2..8)
- DEPTH, 4, FIFO entries (power of 2)
- DATA_W, 8, APB data width
- pclk_i  in  1  clock; everything is on its rising edge
- prst_i  in  1  reset, synchronous, active-high
- paddr_i  in  WIDTH  register address
- pwdata_i  in  DATA_W  write data
- prdata_o  out  DATA_W  read data
- pwrite_i, psel_i, penable_i  in  1  APB controls
- pready_o  out  1  transfer complete
- intr_id_i  in  WIDTH  ID from controller `intr_to_service_o`
- intr_valid_i  in  1  from controller `intr_valid_o`
- intr_ack_o  out  1  one-cycle pulse to controller `intr_serviced_i`
- cpu_intr_req_o  out  NUM_CPU  per-CPU service request, level
- cpu_intr_id_o  out  NUM_CPU*WIDTH  per-CPU ID; CPU c uses bits [c*WIDTH +: WIDTH]
- cpu_done_i  in  NUM_CPU  per-CPU service-complete strobe
- tmo_irq_o  out  1  high while any timeout sticky bit is set

## Operation
- **Reset:**
  - All outputs are 0 and the FIFO is empty.
  - Round-robin pointer gives the next grant to CPU0.
  - EN = all ones, TMO = 0, TSTAT = 0.
  - Asserting reset mid-operation drops all queued and in-flight interrupts.
- **Registers:**
  - Addr 0 EN: [NUM_CPU-1:0] CPU enable mask, RW.
  - Addr 1 TMO: [7:0] timeout in cycles, RW; 0 disables the timeout.
  - Addr 2 TSTAT: [NUM_CPU-1:0] timeout sticky bits; write-1-to-clear.
  - Addr 3 STATUS: RO; [NUM_CPU-1:0] busy mask, next bits hold the FIFO count.
  - Other addresses read 0 and ignore writes.
- **Capture:**
  - Push `intr_id_i` and set `intr_ack_o` to 1 when `intr_valid_i` = 1, the FIFO is not full and `intr_ack_o` = 0.
  - Otherwise `intr_ack_o` goes to 0.
  - The `intr_ack_o` = 0 condition prevents a double push while the controller's valid is still high during the ack cycle.
  - If the FIFO is full, no ack is issued; the controller stalls in its waiting state.
- **Per-CPU state:** IDLE or BUSY.
  - **Dispatch:** at most one per cycle. If the FIFO is non-empty, pop the head to the first IDLE, enabled CPU searching from pointer+1 (modulo NUM_CPU).
  - On dispatch: CPU goes BUSY, `cpu_intr_req_o[c]` = 1, ID driven, timer loaded with TMO, pointer moves to c.
  - **BUSY + `cpu_done_i[c]`:** CPU goes IDLE; req = 0; ID is held.
  - **BUSY with TMO != 0:** timer decrements each cycle. When it reaches 1 without done, CPU goes IDLE and TSTAT[c] is set.
  - If done arrives on the same cycle the timer expires, done wins and TSTAT is not set.
  - `cpu_done_i` while IDLE is ignored.
- **Disabling a CPU** via EN stops new grants to it; an in-flight service finishes normally. With EN = 0 the FIFO fills and upstream stalls.
- **Simultaneous events:**
  - Push and pop in the same cycle: count is unchanged. Push while full is blocked even if a pop happens that cycle.
  - A TSTAT write-1-to-clear in the same cycle a new timeout sets that bit: the set wins.

## Timing
- **APB:** one wait state.
  - `pready_o` = 1 in the cycle after any cycle with psel & penable & !pready_o; otherwise 0.
  - Register write and `prdata_o` load happen on that same edge.
- **Capture:** `intr_ack_o` pulses in the cycle after valid is sampled. The entry is visible in the FIFO in that cycle.
- **Dispatch:** earliest is one cycle after the push, so req rises 2 cycles after the valid cycle.
- **Release:** done sampled at edge N makes req low in cycle N+1. The CPU can be re-granted at edge N+1 at the earliest, never on the edge where done is sampled.
- **Timeout:** with TMO = T and no done, req stays high for exactly T cycles.
- `tmo_irq_o` is registered: it follows TSTAT with 1 cycle latency.

## Test plan
- **Reset then single interrupt:**
  - Stimulus: valid = 1, id = 5 for 2 cycles.
  - Required: exactly one ack pulse; `cpu_intr_req_o` = 01 with CPU0 ID = 5 two cycles after valid; done → req 0 next cycle.
- **Round-robin:**
  - Stimulus: push IDs 1, 2, 3 with no done.
  - Required: ID 1 → CPU0, ID 2 → CPU1, ID 3 stays queued (STATUS count 1) until a done.
- **FIFO full backpressure:**
  - Stimulus: EN = 0; offer 5 interrupts.
  - Required: 4 acks, 5th withheld; STATUS count = 4; writing EN = 11 drains to both CPUs.
- **Timeout:**
  - Stimulus: TMO = 3, no done.
  - Required: req high exactly 3 cycles; TSTAT = 01; `tmo_irq_o` = 1; writing TSTAT = 01 clears both.
- **Done/timeout tie:**
  - Stimulus: done arrives on the expiry cycle.
  - Required: TSTAT stays 0.
- **Mid-operation reset:**
  - Stimulus: prst_i with 2 queued and 2 busy.
  - Required: all outputs 0, count 0, EN = 11 next cycle.
